// File: rtl/egress_arbiter.sv
// Egress arbiter: round-robin selection among ingress FIFOs whose head packet
// targets this output port, then pop, load and hold the packet until accepted.
package packet_pkg;
   localparam int PACKET_WIDTH = 16;
endpackage

module egress_arbiter
   import packet_pkg::*;
#(
   parameter  int NUM_PORTS = 4,
   parameter  int PORT_ID   = 0,
   localparam int HDR_W     = PACKET_WIDTH / 2,
   localparam int GW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_PORTS-1:0][HDR_W-1:0]        hdr_in,
   input  logic [NUM_PORTS-1:0]                   fifo_empty_in,
   input  logic [NUM_PORTS-1:0][PACKET_WIDTH-1:0] fifo_data_in,
   output logic [NUM_PORTS-1:0]                   rd_en_out,
   output logic [PACKET_WIDTH-1:0]                out_data,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [GW-1:0]                          grant_id,
   output logic                                   busy,
   output logic [15:0]                            pkt_count
);

   typedef enum logic [1:0] {IDLE, POP, LOAD, SEND} state_t;

   localparam logic [1:0] DEST = 2'(PORT_ID);

   state_t                    r_state;
   logic [NUM_PORTS-1:0]      r_rd_en;
   logic [PACKET_WIDTH-1:0]   r_out_data;
   logic                      r_out_valid;
   logic [GW-1:0]             r_grant;
   logic [GW-1:0]             r_last_grant;
   logic [15:0]               r_pkt_count;

   logic [NUM_PORTS-1:0]      w_req;
   logic                      w_found;
   logic [GW-1:0]             w_pick;
   logic                      w_hdr_unused;

   // Only the destination field takes part in arbitration.
   assign w_hdr_unused = ^hdr_in;

   always_comb begin
      w_req = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_req[i] = !fifo_empty_in[i] && (hdr_in[i][3:2] == DEST);
      end
   end

   // Search starts just after the last served FIFO and wraps around.
   always_comb begin
      int            v_idx;
      logic [GW-1:0] v_sel;
      w_found = 1'b0;
      w_pick  = '0;
      v_idx   = 0;
      v_sel   = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         v_idx = int'(r_last_grant) + k;
         if (v_idx >= NUM_PORTS) begin
            v_idx = v_idx - NUM_PORTS;
         end
         v_sel = GW'(v_idx);
         if (!w_found && w_req[v_sel]) begin
            w_found = 1'b1;
            w_pick  = v_sel;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_rd_en      <= '0;
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
         r_grant      <= '0;
         r_last_grant <= GW'(NUM_PORTS - 1);
         r_pkt_count  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_grant <= w_pick;
                  r_rd_en <= NUM_PORTS'(1) << w_pick;
                  r_state <= POP;
               end
            end
            POP: begin
               r_rd_en <= '0;
               r_state <= LOAD;
            end
            // FIFO read data is registered, so it is valid one cycle after the pop.
            LOAD: begin
               r_out_data  <= fifo_data_in[r_grant];
               r_out_valid <= 1'b1;
               r_state     <= SEND;
            end
            SEND: begin
               if (out_ready) begin
                  r_out_valid  <= 1'b0;
                  r_last_grant <= r_grant;
                  r_pkt_count  <= r_pkt_count + 16'd1;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rd_en_out = r_rd_en;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign grant_id  = r_grant;
   assign busy      = (r_state != IDLE);
   assign pkt_count = r_pkt_count;

endmodule

// File: doc/egress_arbiter.md
EGRESS_ARBITER -- requirements
Module: egress_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of ingress FIFOs scanned.
REQ-002 SHALL have parameter PORT_ID, default 0: this output port's index, 0..NUM_PORTS-1.
REQ-003 SHALL take PACKET_WIDTH from packet_pkg; HDR_W = PACKET_WIDTH/2.
REQ-004 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port: hdr_in  input  NUM_PORTS x HDR_W  head-of-FIFO header per ingress FIFO; 0 when that FIFO is empty.
REQ-007 SHALL have port: fifo_empty_in  input  NUM_PORTS  per-FIFO empty flag.
REQ-008 SHALL have port: fifo_data_in  input  NUM_PORTS x PACKET_WIDTH  registered FIFO read data; valid one cycle after that FIFO's rd_en.
REQ-009 SHALL have port: rd_en_out  output  NUM_PORTS  per-FIFO pop strobe.
REQ-010 SHALL have port: out_data  output  PACKET_WIDTH  egress packet.
REQ-011 SHALL have port: out_valid  output  1  out_data valid.
REQ-012 SHALL have port: out_ready  input  1  downstream accepts when high with out_valid.
REQ-013 SHALL have port: grant_id  output  $clog2(NUM_PORTS)  ingress index of the packet in flight.
REQ-014 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port: pkt_count  output  16  packets delivered since reset.

Function
REQ-016 SHALL use header bits [3:2] as destination port; req[i] = !fifo_empty_in[i] && hdr_in[i][3:2] == PORT_ID.
REQ-017 SHALL implement FSM states IDLE, POP, LOAD, SEND.
REQ-018 IDLE: if any req, SHALL register grant_id via round-robin and go to POP; otherwise stay in IDLE.
REQ-019 Round-robin SHALL search from last_grant+1 upward modulo NUM_PORTS; first requester wins.
REQ-020 POP: SHALL assert rd_en_out[grant_id] for exactly one cycle, all other bits 0, then go to LOAD.
REQ-021 LOAD: SHALL register fifo_data_in[grant_id] into out_data, set out_valid, go to SEND.
REQ-022 SEND: out_valid high; out_data and grant_id SHALL hold stable while out_ready is low.
REQ-023 SEND with out_ready=1: SHALL clear out_valid next cycle, set last_grant to grant_id, increment pkt_count, and go to IDLE.
REQ-024 Latency: req visible in IDLE at cycle T gives rd_en at T+1 and out_valid at T+3 (min 4 cycles per packet).
REQ-025 Requests SHALL be ignored outside IDLE; a later request from a higher-priority FIFO SHALL NOT preempt the packet in flight.
REQ-026 rd_en_out SHALL never assert for an empty FIFO, a non-matching destination, or outside POP.
REQ-027 pkt_count SHALL wrap from 16'hFFFF to 0.
REQ-028 Header bits other than [3:2] SHALL NOT affect arbitration.

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE, rd_en_out=0, out_valid=0, out_data=0, grant_id=0, busy=0, pkt_count=0, last_grant=NUM_PORTS-1 (FIFO 0 has first priority).
REQ-030 Reset mid-operation SHALL abort the transfer with no further rd_en; a packet already popped is discarded.
REQ-031 Outputs SHALL leave reset values only on the first rising clk edge after rst_n deasserts.

Verification
REQ-032 PORT_ID=1, FIFO2 header 8'h04, others empty, out_ready=1 -> rd_en_out=4'b0100 one cycle at T+1; out_valid at T+3 with FIFO2 data; grant_id=2; pkt_count=1.
REQ-033 FIFO0..3 all headed to PORT_ID, out_ready=1, after reset -> grant order 0,1,2,3,0; one rd_en pulse each; pkt_count=5.
REQ-034 FIFO3 header dest=2 with PORT_ID=0 -> rd_en_out stays 0, busy stays 0.
REQ-035 out_ready held low 10 cycles in SEND -> out_valid and out_data stable, no rd_en pulses, pkt_count unchanged; then out_ready=1 -> one handshake.
REQ-036 rst_n pulsed low during LOAD -> all outputs immediately at reset values; next matching request is granted starting from FIFO 0.
REQ-037 pkt_count preloaded near 16'hFFFF by 2 packets -> reads 16'hFFFF, then 0.
